fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. It owns the program counter and drives the instruction-memory address. It registers the fetched word and its PC for the decode-stage controller. It resolves branch and jump redirects that decode reports, using architectural delay-slot semantics. It also enters a terminal halt state when decode retires a `syscall`.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, decode-stage redirect inputs
// and the IF/ID register outputs. The fetch stage is the master.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_d;
  logic        branch_eq_d;
  logic        abs_jump_d;
  logic        abs_jump_loc_d;
  logic [31:0] immediate_d;
  logic [31:0] rs_val_d;
  logic [31:0] rt_val_d;
  logic        bye_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bubble_d;

  modport master (
    output imem_addr, instr_d, pc_d, pc8_d, bubble_d,
    input  imem_rdata, branch_d, branch_eq_d, abs_jump_d, abs_jump_loc_d,
           immediate_d, rs_val_d, rt_val_d, bye_d
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, pc8_d, bubble_d,
    output imem_rdata, branch_d, branch_eq_d, abs_jump_d, abs_jump_loc_d,
           immediate_d, rs_val_d, rt_val_d, bye_d
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, applies delay-slot branch
// and jump redirects from decode, and stops for good when decode retires syscall.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_RUN  | fetching; PC advances or redirects on unstalled cycles
// ST_HALT | syscall retired; PC frozen, IF/ID holds a bubble until reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  fetch_stage_if.master   bus,
  output logic            halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_bubble_q, ifid_bubble_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        branch_cond;
  logic        fire;
  logic        redirect;
  logic        halt_go;

  // Targets are relative to the instruction in decode, not the fetch PC.
  assign pc_plus4        = ifid_pc_q + 32'd4;
  assign branch_target   = pc_plus4 + (bus.immediate_d << 2);
  assign jump_target     = bus.abs_jump_loc_d
                           ? {pc_plus4[31:28], bus.immediate_d[25:0], 2'b00}
                           : bus.rs_val_d;
  assign redirect_target = bus.abs_jump_d ? jump_target : branch_target;

  assign branch_cond = bus.branch_eq_d ? (bus.rs_val_d == bus.rt_val_d)
                                       : (bus.rs_val_d != bus.rt_val_d);

  assign fire     = (state_q == ST_RUN) && !stall && !ifid_bubble_q;
  assign redirect = fire && (bus.abs_jump_d || (bus.branch_d && branch_cond));
  assign halt_go  = fire && bus.bye_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      ifid_instr_q  <= 32'd0;
      ifid_pc_q     <= 32'd0;
      ifid_bubble_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_bubble_q <= ifid_bubble_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_bubble_d = ifid_bubble_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          fetch_pc_d = redirect ? redirect_target : fetch_pc_q + 32'd4;
          // The word behind syscall is squashed rather than latched.
          if (halt_go) begin
            state_d       = ST_HALT;
            ifid_instr_d  = 32'd0;
            ifid_bubble_d = 1'b1;
          end else begin
            ifid_instr_d  = bus.imem_rdata;
            ifid_pc_d     = fetch_pc_q;
            ifid_bubble_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        ifid_instr_d  = 32'd0;
        ifid_bubble_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.instr_d   = ifid_instr_q;
  assign bus.pc_d      = ifid_pc_q;
  assign bus.pc8_d     = ifid_pc_q + 32'd8;
  assign bus.bubble_d  = ifid_bubble_q;
  assign halted        = (state_q == ST_HALT);

endmodule
